ppu_vram_bus: RTL



---
 rtl/ppu_vram_bus_if.sv | 25 ++
 rtl/ppu_vram_bus.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/ppu_vram_bus_if.sv
// Signal bundle between the PPU/host requesters and the VRAM bus responder.
interface ppu_vram_bus_if;
  logic [13:0] ppu_addr;
  logic [7:0]  ppu_rdata;
  logic        render_active;
  logic        host_req;
  logic        host_we;
  logic [13:0] host_addr;
  logic [7:0]  host_wdata;
  logic        host_ack;
  logic [7:0]  host_rdata;
  logic [4:0]  pal_index;
  logic [5:0]  pal_color;
  logic        init_busy;

  modport master (
    output ppu_addr, render_active, host_req, host_we, host_addr, host_wdata, pal_index,
    input  ppu_rdata, host_ack, host_rdata, pal_color, init_busy
  );

  modport slave (
    input  ppu_addr, render_active, host_req, host_we, host_addr, host_wdata, pal_index,
    output ppu_rdata, host_ack, host_rdata, pal_color, init_busy
  );
endinterface

// File: rtl/ppu_vram_bus.sv
// PPU video-memory responder: CHR-RAM, mirrored CIRAM and palette RAM behind one
// 14-bit decode, with a render read port, a host request/ack port and a colour lookup.
module ppu_vram_bus #(
  parameter bit MIRROR       = 1'b0,
  parameter bit CHR_WRITABLE = 1'b1
) (
  input  logic          clock,
  input  logic          reset,
  ppu_vram_bus_if.slave bus
);
  typedef enum logic [1:0] {REG_CHR, REG_NT, REG_PAL} region_e;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

  logic [7:0] chr_mem   [8192];
  logic [7:0] ciram_mem [2048];
  logic [5:0] pal_mem   [32];

  function automatic region_e region_of(input logic [13:0] a);
    if (!a[13])            return REG_CHR;
    if (a[13:8] == 6'h3F)  return REG_PAL;
    return REG_NT;
  endfunction

  function automatic logic [10:0] ciram_index(input logic [13:0] a);
    return {(MIRROR ? a[10] : a[11]), a[9:0]};
  endfunction

  // Sprite backdrop slots $10/$14/$18/$1C alias the background ones.
  function automatic logic [4:0] pal_fold(input logic [4:0] p);
    return (p[1:0] == 2'b00) ? {1'b0, p[3:0]} : p;
  endfunction

  state_e      state_q, state_d;
  logic        host_access;
  logic        host_write;
  logic [10:0] cnt_q;
  logic        init_busy_q;
  logic [7:0]  render_word;
  logic [7:0]  host_word;
  logic [4:0]  pal_lookup;
  logic [7:0]  ppu_rdata_q;
  logic        host_ack_q;
  logic [7:0]  host_rdata_q;
  logic [5:0]  pal_color_q;

  // Read-side decode (combinational, registered below)
  always_comb begin
    render_word = 8'h00;
    case (region_of(bus.ppu_addr))
      REG_CHR: render_word = chr_mem[bus.ppu_addr[12:0]];
      REG_NT:  render_word = ciram_mem[ciram_index(bus.ppu_addr)];
      default: render_word = {2'b00, pal_mem[pal_fold(bus.ppu_addr[4:0])]};
    endcase
  end

  always_comb begin
    host_word = 8'h00;
    case (region_of(bus.host_addr))
      REG_CHR: host_word = chr_mem[bus.host_addr[12:0]];
      REG_NT:  host_word = ciram_mem[ciram_index(bus.host_addr)];
      default: host_word = {2'b00, pal_mem[pal_fold(bus.host_addr[4:0])]};
    endcase
  end

  assign pal_lookup = (bus.pal_index[1:0] == 2'b00) ? 5'd0 : bus.pal_index;

  // Host FSM
  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    host_access = 1'b0;
    case (state_q)
      IDLE:    if (bus.host_req && !bus.render_active && !init_busy_q) state_d = ACCESS;
      ACCESS:  begin
        host_access = 1'b1;
        state_d     = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign host_write = host_access && bus.host_we;

  // Clear sequencer
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= 11'd0;
      init_busy_q <= 1'b1;
    end else if (init_busy_q) begin
      cnt_q <= cnt_q + 11'd1;
      if (cnt_q == 11'h7FF) init_busy_q <= 1'b0;
    end
  end

  // Memory write ports; host writes can only occur once the sequencer is idle
  always_ff @(posedge clock) begin
    if (!reset && CHR_WRITABLE && host_write && region_of(bus.host_addr) == REG_CHR)
      chr_mem[bus.host_addr[12:0]] <= bus.host_wdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (init_busy_q)
        ciram_mem[cnt_q] <= 8'h00;
      else if (host_write && region_of(bus.host_addr) == REG_NT)
        ciram_mem[ciram_index(bus.host_addr)] <= bus.host_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      if (init_busy_q) begin
        if (cnt_q < 11'd32) pal_mem[cnt_q[4:0]] <= 6'h00;
      end else if (host_write && region_of(bus.host_addr) == REG_PAL) begin
        pal_mem[pal_fold(bus.host_addr[4:0])] <= bus.host_wdata[5:0];
      end
    end
  end

  // Registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      ppu_rdata_q  <= 8'h00;
      host_ack_q   <= 1'b0;
      host_rdata_q <= 8'h00;
      pal_color_q  <= 6'h00;
    end else begin
      ppu_rdata_q <= init_busy_q ? 8'h00 : render_word;
      host_ack_q  <= (state_q == DONE);
      if (host_access && !bus.host_we) host_rdata_q <= host_word;
      pal_color_q <= pal_mem[pal_lookup];
    end
  end

  assign bus.ppu_rdata  = ppu_rdata_q;
  assign bus.host_ack   = host_ack_q;
  assign bus.host_rdata = host_rdata_q;
  assign bus.pal_color  = pal_color_q;
  assign bus.init_busy  = init_busy_q;
endmodule
